dds_multi_gen: RTL and testbench

Multi-channel, parametrised direct digital synthesis (DDS) generator. It replaces the single-channel, key-selected, ASCII-tuned wave source that drives the board DAC. Each channel has its own phase accumulator, frequency word, phase offset, waveform mode, amplitude and enable. Channels are programmed through a checksummed binary command frame arriving byte-wise from the UART receiver. The block sits between the UART receive path and the DAC pins, and uses an external per-channel sine LUT ROM.

---
 rtl/dds_multi_gen_if.sv | 28 ++
 rtl/dds_multi_gen.sv | 276 +++++++++++++++++++++++++++
 tb/tb_dds_multi_gen.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dds_multi_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : dds_multi_gen_if
// Description : Byte-wise command channel between the UART receiver and the
//               DDS generator: received-byte strobe in, ack/err pulses out.
// Revision    : 1.0 - initial release
// ============================================================================
interface dds_multi_gen_if;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_ack;
  logic       cmd_err;

  modport master (
    output cmd_valid,
    output cmd_data,
    input  cmd_ack,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    output cmd_ack,
    output cmd_err
  );
endinterface
`default_nettype wire

// File: rtl/dds_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : dds_multi_gen
// Description : Multi-channel DDS generator. Each channel has a phase
//               accumulator, frequency word, phase offset, waveform mode,
//               amplitude and enable, programmed through a checksummed
//               7-byte command frame. Output latency is 4 cycles in all modes.
// Revision    : 1.0 - initial release
// ============================================================================
module dds_multi_gen #(
  parameter int CHANNELS  = 2,
  parameter int ACC_W     = 32,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int FREQ_INIT = 85899,
  parameter int TIMEOUT   = 500000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  dds_multi_gen_if.slave             cmd,
  output logic [CHANNELS*ADDR_W-1:0] lut_addr,
  input  logic [CHANNELS*DATA_W-1:0] lut_data,
  output logic [CHANNELS*DATA_W-1:0] dac_data
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int TO_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam int MID  = 2 ** (DATA_W - 1);
  // Scaling arithmetic width: signed (DATA_W+1)-bit difference times 9-bit gain
  localparam int SW   = DATA_W + 10;
  // Only the top DATA_W+1 phase bits are needed by the internal waveforms
  localparam int PH_W = DATA_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [7:0]      cmd_byte;
  logic [7:0]      chk_acc;
  logic [31:0]     data_word;
  logic [1:0]      byte_cnt;
  logic [TO_W-1:0] idle_cnt;
  logic            frame_done;
  logic            frame_ok;
  logic            addr_ok;
  logic            ack_r;
  logic            err_r;
  logic            wr_en;
  logic            sync;
  logic [3:0]      wr_ch;
  logic [3:0]      wr_reg;

  assign wr_ch  = cmd_byte[7:4];
  assign wr_reg = cmd_byte[3:0];

  // Sync ignores the channel field; every other register needs an existing channel
  assign addr_ok = (wr_reg == 4'd5) ||
                   ((wr_reg < 4'd5) && ({1'b0, wr_ch} < 5'(CHANNELS)));

  assign wr_en = frame_done && frame_ok;
  assign sync  = wr_en && (wr_reg == 4'd5);

  assign cmd.cmd_ack = ack_r;
  assign cmd.cmd_err = err_r;

  // Parser next-state and frame verdict
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    frame_ok   = 1'b0;
    case (state)
      IDLE: if (cmd.cmd_valid && (cmd.cmd_data == SYNC_BYTE)) state_nxt = CMD;
      CMD:  if (cmd.cmd_valid) state_nxt = DATA;
      DATA: if (cmd.cmd_valid && (byte_cnt == 2'd3)) state_nxt = CHK;
      CHK: begin
        if (cmd.cmd_valid) begin
          state_nxt  = IDLE;
          frame_done = 1'b1;
          frame_ok   = (cmd.cmd_data == chk_acc) && addr_ok;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A stalled frame is dropped silently once the idle budget is exhausted
    if ((state != IDLE) && !cmd.cmd_valid && (idle_cnt == TO_W'(TIMEOUT)))
      state_nxt = IDLE;
  end

  // Parser state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Frame assembly: command byte, big-endian data word and running checksum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_byte  <= 8'd0;
      chk_acc   <= 8'd0;
      data_word <= 32'd0;
      byte_cnt  <= 2'd0;
    end else if (cmd.cmd_valid) begin
      case (state)
        CMD: begin
          cmd_byte <= cmd.cmd_data;
          chk_acc  <= cmd.cmd_data;
          byte_cnt <= 2'd0;
        end
        DATA: begin
          data_word <= {data_word[23:0], cmd.cmd_data};
          chk_acc   <= chk_acc ^ cmd.cmd_data;
          byte_cnt  <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // Idle-cycle counter for the inter-byte timeout, saturating at TIMEOUT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      idle_cnt <= '0;
    else if ((state == IDLE) || cmd.cmd_valid)
      idle_cnt <= '0;
    else if (idle_cnt != TO_W'(TIMEOUT))
      idle_cnt <= idle_cnt + 1'b1;
  end

  // One-cycle verdict pulses, aligned with the register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      err_r <= 1'b0;
    end else begin
      ack_r <= frame_done && frame_ok;
      err_r <= frame_done && !frame_ok;
    end
  end

  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [ACC_W-1:0]     freq;
    logic [ACC_W-1:0]     offset;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     ph;
    logic [1:0]           mode;
    logic [7:0]           amp;
    logic                 en;
    logic                 sel;
    logic [ADDR_W-1:0]    addr_r;
    logic [PH_W-1:0]      ph1;
    logic [PH_W-1:0]      ph2;
    logic [1:0]           mode1;
    logic [1:0]           mode2;
    logic [7:0]           amp1;
    logic [7:0]           amp2;
    logic [7:0]           amp3;
    logic                 en1;
    logic                 en2;
    logic                 en3;
    logic [DATA_W-1:0]    lut_k;
    logic [DATA_W-1:0]    wave;
    logic [DATA_W-1:0]    wave3;
    logic [DATA_W-1:0]    scaled;
    logic [DATA_W-1:0]    dac_r;
    logic signed [SW-1:0] diff;
    logic signed [SW-1:0] gain;
    logic signed [SW-1:0] prod;
    logic signed [SW-1:0] sum;

    assign sel   = wr_en && (wr_ch == 4'(k));
    assign ph    = acc + offset;
    assign lut_k = lut_data[k*DATA_W +: DATA_W];

    assign lut_addr[k*ADDR_W +: ADDR_W] = addr_r;
    assign dac_data[k*DATA_W +: DATA_W] = dac_r;

    // Channel register file, written by an accepted frame
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        freq   <= ACC_W'(FREQ_INIT);
        offset <= '0;
        mode   <= 2'd0;
        amp    <= 8'hFF;
        en     <= 1'b1;
      end else if (sel) begin
        case (wr_reg)
          4'd0:    freq   <= data_word[ACC_W-1:0];
          4'd1:    offset <= data_word[ACC_W-1:0];
          4'd2:    mode   <= data_word[1:0];
          4'd3:    amp    <= data_word[7:0];
          4'd4:    en     <= data_word[0];
          default: ;
        endcase
      end
    end

    // Phase accumulator; a sync clear overrides the step and the enable
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    acc <= '0;
      else if (sync) acc <= '0;
      else if (en)   acc <= acc + freq;
    end

    // Stages 1-2: ROM address and phase/config carried alongside the ROM read
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        addr_r <= '0;
        ph1    <= '0;
        ph2    <= '0;
        mode1  <= 2'd0;
        mode2  <= 2'd0;
        amp1   <= 8'hFF;
        amp2   <= 8'hFF;
        en1    <= 1'b0;
        en2    <= 1'b0;
      end else begin
        addr_r <= ADDR_W'(ph >> (ACC_W - ADDR_W));
        ph1    <= PH_W'(ph >> (ACC_W - PH_W));
        ph2    <= ph1;
        mode1  <= mode;
        mode2  <= mode1;
        amp1   <= amp;
        amp2   <= amp1;
        en1    <= en;
        en2    <= en1;
      end
    end

    // Waveform selection, lined up with the ROM data
    always_comb begin
      wave = lut_k;
      case (mode2)
        2'd0:    wave = lut_k;
        2'd1:    wave = ph2[PH_W-1] ? '1 : '0;
        2'd2:    wave = ph2[PH_W-1] ? ~ph2[PH_W-2:0] : ph2[PH_W-2:0];
        2'd3:    wave = ph2[PH_W-1 -: DATA_W];
        default: wave = lut_k;
      endcase
    end

    // Stage 3: registered waveform sample
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wave3 <= DATA_W'(MID);
        amp3  <= 8'hFF;
        en3   <= 1'b0;
      end else begin
        wave3 <= wave;
        amp3  <= amp2;
        en3   <= en2;
      end
    end

    // Amplitude scaling about midscale with an arithmetic shift
    always_comb begin
      diff   = $signed(SW'(wave3)) - $signed(SW'(MID));
      gain   = $signed(SW'(amp3)) + $signed(SW'(1));
      prod   = diff * gain;
      sum    = $signed(SW'(MID)) + (prod >>> 8);
      scaled = DATA_W'(sum);
    end

    // Stage 4: output sample, midscale while disabled
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) dac_r <= DATA_W'(MID);
      else        dac_r <= en3 ? scaled : DATA_W'(MID);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_multi_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_dds_multi_gen
// Description : Self-checking bench for dds_multi_gen: behavioural frame and
//               waveform model, per-cycle compare, directed and random frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dds_multi_gen;
  localparam int CH        = 2;
  localparam int ACC_W     = 32;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int FREQ_INIT = 85899;
  localparam int TIMEOUT   = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [CH*8-1:0] lut_addr;
  logic [CH*8-1:0] lut_data = '0;
  logic [CH*8-1:0] dac_data;

  dds_multi_gen_if bus();

  dds_multi_gen #(
    .CHANNELS (CH),
    .ACC_W    (ACC_W),
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .FREQ_INIT(FREQ_INIT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cmd     (bus),
    .lut_addr(lut_addr),
    .lut_data(lut_data),
    .dac_data(dac_data)
  );

  always #5 clk = ~clk;

  // Sine ROM with one-cycle read latency
  logic [7:0] rom [256];
  always @(posedge clk)
    for (int c = 0; c < CH; c++) lut_data[c*8 +: 8] <= rom[lut_addr[c*8 +: 8]];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_freq [CH];
  logic [31:0] m_off  [CH];
  logic [31:0] m_acc  [CH];
  logic [1:0]  m_mode [CH];
  logic [7:0]  m_amp  [CH];
  logic        m_en   [CH];
  logic [7:0]  e_dac  [CH][4];
  logic [7:0]  e_addr [CH];
  logic        e_ack;
  logic        e_err;
  logic [7:0]  fbuf [$];
  int          gap;

  function automatic logic [7:0] sample(input logic [31:0] ph, input logic [1:0] mode,
                                        input logic [7:0] amp, input logic en);
    int w;
    int d;
    int g;
    if (!en) return 8'h80;
    case (mode)
      2'd0:    w = rom[ph[31:24]];
      2'd1:    w = ph[31] ? 255 : 0;
      2'd2:    w = ph[31] ? 255 - int'(ph[30:23]) : int'(ph[30:23]);
      default: w = ph[31:24];
    endcase
    d = w - 128;
    g = int'(amp) + 1;
    return 8'(128 + ((d * g) >>> 8));
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_freq[c] = FREQ_INIT;
      m_off[c]  = 0;
      m_acc[c]  = 0;
      m_mode[c] = 0;
      m_amp[c]  = 8'hFF;
      m_en[c]   = 1'b1;
      e_addr[c] = 0;
      for (int i = 0; i < 4; i++) e_dac[c][i] = 8'h80;
    end
    e_ack = 1'b0;
    e_err = 1'b0;
    fbuf.delete();
    gap = 0;
  endtask

  task automatic model_step();
    logic [31:0] ph;
    logic [31:0] d;
    logic [7:0]  cb;
    logic        ok;
    int          r;
    int          ch;
    for (int c = 0; c < CH; c++) begin
      ph = m_acc[c] + m_off[c];
      e_addr[c] = ph[31:24];
      for (int i = 3; i > 0; i--) e_dac[c][i] = e_dac[c][i-1];
      e_dac[c][0] = sample(ph, m_mode[c], m_amp[c], m_en[c]);
    end
    for (int c = 0; c < CH; c++) if (m_en[c]) m_acc[c] = m_acc[c] + m_freq[c];
    e_ack = 1'b0;
    e_err = 1'b0;
    if (bus.cmd_valid) begin
      gap = 0;
      if (fbuf.size() != 0 || bus.cmd_data == 8'hA5) fbuf.push_back(bus.cmd_data);
      if (fbuf.size() == 7) begin
        cb = fbuf[1];
        d  = {fbuf[2], fbuf[3], fbuf[4], fbuf[5]};
        r  = int'(cb[3:0]);
        ch = int'(cb[7:4]);
        ok = ((cb ^ fbuf[2] ^ fbuf[3] ^ fbuf[4] ^ fbuf[5]) == fbuf[6]) &&
             (r <= 5) && (r == 5 || ch < CH);
        if (ok) begin
          case (r)
            0: m_freq[ch] = d;
            1: m_off[ch]  = d;
            2: m_mode[ch] = d[1:0];
            3: m_amp[ch]  = d[7:0];
            4: m_en[ch]   = d[0];
            default: for (int c = 0; c < CH; c++) m_acc[c] = 0;
          endcase
        end
        e_ack = ok;
        e_err = !ok;
        fbuf.delete();
      end
    end else if (fbuf.size() != 0) begin
      gap++;
      if (gap > TIMEOUT) begin
        fbuf.delete();
        gap = 0;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (chk_on) begin
        for (int c = 0; c < CH; c++) begin
          cmp($sformatf("dac_ch%0d", c), 32'(dac_data[c*8 +: 8]), 32'(e_dac[c][3]));
          cmp($sformatf("lut_addr_ch%0d", c), 32'(lut_addr[c*8 +: 8]), 32'(e_addr[c]));
        end
        cmp("cmd_ack", 32'(bus.cmd_ack), 32'(e_ack));
        cmp("cmd_err", 32'(bus.cmd_err), 32'(e_err));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic put_byte(input logic [7:0] b);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 8'($urandom);
    end
  endtask

  task automatic send7(input logic [55:0] f);
    for (int i = 6; i >= 0; i--) put_byte(f[i*8 +: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  cb;
    logic [7:0]  ck;
    logic [31:0] d;
    logic [7:0]  fr [7];
    logic [7:0]  saw [5];
    logic [7:0]  sq  [5];
    int          r;

    for (int i = 0; i < 256; i++)
      rom[i] = 8'($rtoi(127.0 * $sin(2.0 * 3.14159265358979 * i / 256.0) + 128.5));
    saw = '{8'h00, 8'h40, 8'h80, 8'hC0, 8'h00};
    sq  = '{8'h40, 8'h40, 8'hBF, 8'hBF, 8'h40};
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;

    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_dac", 32'(dac_data), 32'h8080);
    cmp("reset_lut_addr", 32'(lut_addr), 32'h0);
    #2 rst_n = 1'b1;

    // accumulator step pin: 10 clock edges after release
    repeat (10) @(negedge clk);
    cmp("model_acc_10_steps", m_acc[0], 32'd858990);

    // ch0 sawtooth, ch1 square at amp 127, both at quarter-rate, then sync
    send7(56'hA5_02_00_00_00_03_01);
    idle(1);
    cmp("ack_mode_frame", 32'(bus.cmd_ack), 32'd1);
    send7(56'hA5_00_40_00_00_00_40);
    send7(56'hA5_12_00_00_00_01_13);
    send7(56'hA5_10_40_00_00_00_50);
    send7(56'hA5_13_00_00_00_7F_6C);
    send7(56'hA5_05_00_00_00_00_05);
    idle(1);
    cmp("ack_sync_frame", 32'(bus.cmd_ack), 32'd1);
    idle(3);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      cmp($sformatf("saw_step%0d", i), 32'(dac_data[7:0]), 32'(saw[i]));
      cmp($sformatf("square_step%0d", i), 32'(dac_data[15:8]), 32'(sq[i]));
    end

    // bad checksum: one-cycle err, then a good frame is acked
    send7(56'hA5_00_00_00_00_01_00);
    idle(1);
    cmp("err_bad_chk", 32'(bus.cmd_err), 32'd1);
    cmp("no_ack_bad_chk", 32'(bus.cmd_ack), 32'd0);
    idle(1);
    cmp("err_single_cycle", 32'(bus.cmd_err), 32'd0);
    send7(56'hA5_00_40_00_00_00_40);
    idle(1);
    cmp("ack_after_bad", 32'(bus.cmd_ack), 32'd1);

    // timeout: TIMEOUT+1 idle cycles discards the partial frame
    put_byte(8'hA5); put_byte(8'h00); put_byte(8'h00);
    idle(TIMEOUT + 1);
    send7(56'hA5_03_00_00_00_FF_FC);
    idle(1);
    cmp("ack_after_timeout", 32'(bus.cmd_ack), 32'd1);
    cmp("no_err_after_timeout", 32'(bus.cmd_err), 32'd0);

    // exactly TIMEOUT idle cycles keeps the frame alive
    put_byte(8'hA5); put_byte(8'h03);
    idle(TIMEOUT);
    put_byte(8'h00); put_byte(8'h00); put_byte(8'h00); put_byte(8'hFF); put_byte(8'hFC);
    idle(1);
    cmp("ack_at_timeout_edge", 32'(bus.cmd_ack), 32'd1);

    // reset mid-frame loses the partial frame
    put_byte(8'hA5); put_byte(8'h04); put_byte(8'h00);
    idle(1);
    #2 rst_n = 1'b0;
    idle(2);
    #2 rst_n = 1'b1;
    put_byte(8'h00); put_byte(8'h00); put_byte(8'h00); put_byte(8'h04);
    idle(1);
    cmp("no_ack_after_reset", 32'(bus.cmd_ack), 32'd0);
    cmp("no_err_after_reset", 32'(bus.cmd_err), 32'd0);

    // randomized frames with junk bytes, gaps, bad checksums and bad addresses
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 5) == 0) put_byte(8'($urandom_range(0, 255)));
      r  = int'($urandom_range(0, 6));
      cb = {4'($urandom_range(0, 2)), 4'(r)};
      d  = $urandom;
      if (r == 0 && $urandom_range(0, 1) == 1) d = $urandom_range(0, 32'h0400_0000);
      if (r == 4) d[0] = ($urandom_range(0, 3) != 0);
      ck = cb ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if ($urandom_range(0, 7) == 0) ck = ck ^ 8'($urandom_range(1, 255));
      fr = '{8'hA5, cb, d[31:24], d[23:16], d[15:8], d[7:0], ck};
      for (int b = 0; b < 7; b++) begin
        put_byte(fr[b]);
        if (b < 6) begin
          case ($urandom_range(0, 19))
            14, 15, 16, 17: idle(int'($urandom_range(1, 2)));
            18:             idle(TIMEOUT);
            19:             idle(TIMEOUT + 1);
            default:        ;
          endcase
        end
      end
      idle(int'($urandom_range(0, 3)));
    end

    idle(8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
